game_status_display: RTL and testbench

GAME_STATUS_DISPLAY -- requirements
Module: game_status_display

---
 rtl/game_status_display.sv | 182 ++++++++++++++++++
 tb/tb_game_status_display.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/game_status_display.sv
// Game status display: tracks game state (idle/playing/won/lost), keeps the
// revealed-cell count as BCD digits and drives active-low seven-segment digits.
module game_status_display #(
    parameter int NUM_DIGITS = 2,
    parameter int SAFE_CELLS = 90,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    cell_revealed,
    input  logic                    mine_hit,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic                    game_over,
    output logic                    won
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PLAYING = 2'd1;
    localparam logic [1:0] ST_WON     = 2'd2;
    localparam logic [1:0] ST_LOST    = 2'd3;

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // Elaboration-time conversion of the win threshold to BCD; no hardware.
    function automatic logic [4*NUM_DIGITS-1:0] f_to_bcd(input int value);
        logic [4*NUM_DIGITS-1:0] result;
        int v;
        v      = value;
        result = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            result[4*i +: 4] = 4'(v % 10);
            v                = v / 10;
        end
        return result;
    endfunction

    function automatic logic [6:0] f_seg(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

    localparam logic [4*NUM_DIGITS-1:0] SAFE_BCD = f_to_bcd(SAFE_CELLS);

    logic [1:0]              r_state;
    logic [4*NUM_DIGITS-1:0] r_count;
    logic [CNT_W-1:0]        r_blink_cnt;
    logic                    r_phase_on;
    logic                    r_game_over;
    logic                    r_won;

    logic [1:0]              w_state_d;
    logic [4*NUM_DIGITS-1:0] w_count_d;
    logic [4*NUM_DIGITS-1:0] w_count_inc;
    logic [CNT_W-1:0]        w_blink_cnt_d;
    logic                    w_phase_on_d;
    logic                    w_at_max;

    // BCD increment with ripple carry across digits
    always_comb begin
        logic v_carry;
        v_carry     = 1'b1;
        w_count_inc = r_count;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v_carry) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_count_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_count_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    v_carry               = 1'b0;
                end
            end
        end
    end

    assign w_at_max = (r_count == SAFE_BCD);

    // Next state and count; start beats mine_hit beats cell_revealed
    always_comb begin
        w_state_d = r_state;
        w_count_d = r_count;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_d = ST_PLAYING;
                    w_count_d = '0;
                end
            end
            ST_PLAYING: begin
                if (start) begin
                    w_count_d = '0;
                end else if (mine_hit) begin
                    w_state_d = ST_LOST;
                end else if (cell_revealed && !w_at_max) begin
                    w_count_d = w_count_inc;
                    if (w_count_inc == SAFE_BCD) begin
                        w_state_d = ST_WON;
                    end
                end
            end
            ST_WON, ST_LOST: begin
                if (start) begin
                    w_state_d = ST_PLAYING;
                    w_count_d = '0;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_count_d = '0;
            end
        endcase
    end

    // Blink timer: runs only while staying in LOST, restarts "on" at entry
    always_comb begin
        w_blink_cnt_d = '0;
        w_phase_on_d  = 1'b1;
        if (r_state == ST_LOST && w_state_d == ST_LOST) begin
            if (r_blink_cnt == BLINK_LAST) begin
                w_blink_cnt_d = '0;
                w_phase_on_d  = ~r_phase_on;
            end else begin
                w_blink_cnt_d = r_blink_cnt + 1'b1;
                w_phase_on_d  = r_phase_on;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_blink_cnt <= '0;
            r_phase_on  <= 1'b1;
            r_game_over <= 1'b0;
            r_won       <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_count     <= w_count_d;
            r_blink_cnt <= w_blink_cnt_d;
            r_phase_on  <= w_phase_on_d;
            r_game_over <= (w_state_d == ST_LOST);
            r_won       <= (w_state_d == ST_WON);
        end
    end

    // Segment decode from registered state, count and blink phase
    always_comb begin
        seg = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            case (r_state)
                ST_PLAYING: seg[7*i +: 7] = f_seg(r_count[4*i +: 4]);
                ST_WON:     seg[7*i +: 7] = SEG_ONE;
                ST_LOST:    seg[7*i +: 7] = r_phase_on ? SEG_ZERO : SEG_BLANK;
                default:    seg[7*i +: 7] = SEG_BLANK;
            endcase
        end
    end

    assign game_over = r_game_over;
    assign won       = r_won;

endmodule

// File: tb/tb_game_status_display.sv
// Directed bench for game_status_display with NUM_DIGITS=2, SAFE_CELLS=3,
// BLINK_DIV=4. Inputs change 1 ns after a rising edge; outputs are sampled there.
module tb_game_status_display;

    localparam logic [6:0] D_BLANK = 7'b1111111;
    localparam logic [6:0] D_ZERO  = 7'b1000000;
    localparam logic [6:0] D_ONE   = 7'b1111001;
    localparam logic [6:0] D_TWO   = 7'b0100100;

    logic        clk;
    logic        reset;
    logic        start;
    logic        cell_revealed;
    logic        mine_hit;
    logic [13:0] seg;
    logic        game_over;
    logic        won;

    int n_checks;
    int n_errors;

    game_status_display #(
        .NUM_DIGITS(2),
        .SAFE_CELLS(3),
        .BLINK_DIV (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cell_revealed(cell_revealed),
        .mine_hit     (mine_hit),
        .seg          (seg),
        .game_over    (game_over),
        .won          (won)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of inputs, then return them to idle
    task automatic pulse(input logic s, input logic c, input logic m);
        start         = s;
        cell_revealed = c;
        mine_hit      = m;
        tick();
        start         = 1'b0;
        cell_revealed = 1'b0;
        mine_hit      = 1'b0;
    endtask

    initial begin
        logic [6:0] exp_digit;
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b0;
        start         = 1'b0;
        cell_revealed = 1'b0;
        mine_hit      = 1'b0;
        #1;
        tick();
        tick();
        reset = 1'b1;

        // Reset state
        check("rst_seg", 32'(seg), 32'h3FFF);
        check("rst_go", 32'(game_over), 0);
        check("rst_won", 32'(won), 0);
        pulse(1'b0, 1'b1, 1'b1);
        check("idle_ignores", 32'(seg), 32'h3FFF);
        check("idle_go", 32'(game_over), 0);

        // Start and count
        pulse(1'b1, 1'b0, 1'b0);
        check("start_seg", 32'(seg), 32'({D_ZERO, D_ZERO}));
        pulse(1'b0, 1'b1, 1'b0);
        check("cnt1_seg", 32'(seg), 32'({D_ZERO, D_ONE}));
        pulse(1'b0, 1'b1, 1'b0);
        check("cnt2_seg", 32'(seg), 32'({D_ZERO, D_TWO}));
        check("cnt2_won", 32'(won), 0);

        // Win at SAFE_CELLS, then further inputs ignored
        pulse(1'b0, 1'b1, 1'b0);
        check("win_won", 32'(won), 1);
        check("win_seg", 32'(seg), 32'({D_ONE, D_ONE}));
        check("win_go", 32'(game_over), 0);
        pulse(1'b0, 1'b1, 1'b0);
        check("win_hold_seg", 32'(seg), 32'({D_ONE, D_ONE}));
        check("win_hold_won", 32'(won), 1);
        pulse(1'b0, 1'b0, 1'b1);
        check("win_mine_go", 32'(game_over), 0);
        check("win_mine_won", 32'(won), 1);

        // Restart from WON; start beats mine_hit while playing
        pulse(1'b1, 1'b0, 1'b0);
        check("restart_seg", 32'(seg), 32'({D_ZERO, D_ZERO}));
        check("restart_won", 32'(won), 0);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b1);
        check("prio_seg", 32'(seg), 32'({D_ZERO, D_ZERO}));
        check("prio_go", 32'(game_over), 0);

        // Lose: one cell, then mine_hit together with cell_revealed
        pulse(1'b0, 1'b1, 1'b0);
        check("lose_pre_seg", 32'(seg), 32'({D_ZERO, D_ONE}));
        pulse(1'b0, 1'b1, 1'b1);
        check("lose_go", 32'(game_over), 1);
        check("lose_won", 32'(won), 0);
        // Blink: 4 cycles "0", 4 cycles blank, repeating
        for (int i = 0; i < 12; i++) begin
            exp_digit = (((i / 4) % 2) == 0) ? D_ZERO : D_BLANK;
            check($sformatf("blink%0d", i), 32'(seg), 32'({exp_digit, exp_digit}));
            if (i != 11) tick();
        end
        check("blink_go", 32'(game_over), 1);

        // Restart from LOST
        pulse(1'b1, 1'b0, 1'b0);
        check("lost_restart_seg", 32'(seg), 32'({D_ZERO, D_ZERO}));
        check("lost_restart_go", 32'(game_over), 0);
        // Count was cleared: one cell shows "01"
        pulse(1'b0, 1'b1, 1'b0);
        check("lost_restart_cnt", 32'(seg), 32'({D_ZERO, D_ONE}));

        // Lose again and reset mid-blink in the off phase
        pulse(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        check("off_phase_seg", 32'(seg), 32'({D_BLANK, D_BLANK}));
        reset = 1'b0;
        start = 1'b1;
        tick();
        check("midrst_seg", 32'(seg), 32'h3FFF);
        check("midrst_go", 32'(game_over), 0);
        check("midrst_won", 32'(won), 0);
        tick();
        check("rst_held_seg", 32'(seg), 32'h3FFF);
        reset = 1'b1;
        start = 1'b0;
        tick();
        check("rel_seg", 32'(seg), 32'h3FFF);
        pulse(1'b1, 1'b0, 1'b0);
        check("first_start_seg", 32'(seg), 32'({D_ZERO, D_ZERO}));
        check("first_start_go", 32'(game_over), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
